// File: rtl/uart_tx_fifo_if.sv
// Producer-side byte handshake for the buffered UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO of pending words feeds a start/data/parity/stop
// serialiser that sends frames back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DATA_BITS        = 8,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 in_if,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          txd
);

  localparam int T    = 2 * CLK_PER_HALF_BIT;
  localparam int TF   = (T * 9) / 10;
  localparam int CW   = $clog2(T + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   T_LAST   = CW'(T - 1);
  localparam logic [CW-1:0]   TF_LAST  = CW'(TF - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] FULL     = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      count_q;
  logic                 ready;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign ready        = (count_q != FULL);
  assign in_if.in_ready = ready;
  assign push         = in_if.in_valid && ready;
  assign head         = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_if.in_data[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_first_q, stop_first_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;
  logic                 load;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    two_stop_d   = two_stop_q;
    stop_first_d = stop_first_q;
    txd_d        = txd_q;
    busy_d       = busy_q;
    load         = 1'b0;
    pop          = 1'b0;

    // Only the final stop bit is shortened; a leading stop bit of a pair runs full T.
    bit_end = (cnt_q == ((state_q == S_STOP && !stop_first_q) ? TF_LAST : T_LAST));

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d      = S_STOP;
              txd_d        = 1'b1;
              stop_first_d = two_stop_q;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d      = S_STOP;
          txd_d        = 1'b1;
          stop_first_d = two_stop_q;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_first_q) begin
            stop_first_d = 1'b0;
          end else if (count_q != '0) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        txd_d   = 1'b1;
      end
    endcase

    // Pop the head word and snapshot the line configuration for the whole frame.
    if (load) begin
      pop        = 1'b1;
      state_d    = S_START;
      cnt_d      = '0;
      txd_d      = 1'b0;
      busy_d     = 1'b1;
      shift_d    = head;
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d  = (^head) ^ parity_mode[1];
      two_stop_d = two_stop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      two_stop_q   <= 1'b0;
      stop_first_q <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_bit_q    <= par_bit_d;
      two_stop_q   <= two_stop_d;
      stop_first_q <= stop_first_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_count = count_q;
  assign tx_busy    = busy_q;
  assign txd        = txd_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `txd`. It supports configurable data width, optional even/odd parity and one or two stop bits. It is the next-generation transmit path for the host link, replacing the single-byte unbuffered transmitter so that producers can burst data without polling `tx_busy`. Frames leave back-to-back with no idle gap while the FIFO holds data.

## Interface
- `CLK_PER_HALF_BIT`, default 5208: half a bit period in clk cycles. Full bit period T = 2*CLK_PER_HALF_BIT. Final stop bit Tf = (T*9)/10 (integer division).
- `DATA_BITS`, default 8: data bits per frame, legal 5..8.
- `FIFO_DEPTH`, default 16: FIFO entries, power of two, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  byte to send; only bits [DATA_BITS-1:0] are used, upper bits ignored.
- `in_valid`  in  1  producer has data.
- `in_ready`  out  1  FIFO not full; push occurs on a rising edge where `in_valid && in_ready`.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `two_stop`  in  1  0: one stop bit, 1: two stop bits.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries currently buffered, excluding the frame in flight.
- `tx_busy`  out  1  frame in progress.
- `txd`  out  1  serial line, registered, idle high.

## Operation
- Reset values: `txd`=1, `tx_busy`=0, `fifo_count`=0, `in_ready`=1. FSM returns to IDLE, the baud counter clears and FIFO contents are discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty: pop the head, latch word, `parity_mode` and `two_stop`, drive `txd`=0, set `tx_busy`, clear the baud counter.
  - START -> DATA after T cycles.
  - DATA sends bit index 0..DATA_BITS-1, T cycles each.
  - After the last data bit: -> PARITY if parity is enabled, else -> STOP.
  - PARITY sends for T cycles. Even: XOR of the data bits. Odd: inverted XOR.
  - STOP drives `txd`=1. With `two_stop`, the first stop bit lasts T; the final stop bit lasts Tf.
- At the end of the final stop bit:
  - FIFO non-empty: pop and enter START on that same edge (`txd`=0, `tx_busy` stays 1).
  - FIFO empty: enter IDLE and clear `tx_busy`.
- Configuration inputs are sampled only at the pop. Changes mid-frame affect only the next frame.
- FIFO behaviour:
  - `in_ready` = !(fifo_count == FIFO_DEPTH), derived from registered state (no combinational path from `in_valid`).
  - Push and pop on the same edge leave `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push while full is impossible by construction. `in_valid` held while `in_ready`=0 is a stall, not data loss.
- Ordering: strict FIFO order, one frame per accepted word.

## Timing
- Push into an empty FIFO while IDLE at edge k: `fifo_count`=1 after k, pop at k+1, `txd`=0 and `tx_busy`=1 after k+1, `fifo_count` back to 0.
- Frame duration from the start-bit edge: (1 + DATA_BITS + P + S - 1)*T + Tf cycles, where P is 0 or 1 for parity and S is 1 or 2 for stop bits.
- Every `txd` transition occurs on a bit-boundary edge and never glitches within a bit.
- Defaults (8N1): T=10416, Tf=9374, frame = 9*10416 + 9374 = 103118 cycles.
- Reset asserted mid-frame: at that edge `txd`=1, `tx_busy`=0, FIFO is flushed and the partial frame is abandoned. Operation resumes on the first edge after `rst` deasserts.
- Reset has priority over a simultaneous push. A word presented during reset is not accepted.

## Test plan
All scenarios use CLK_PER_HALF_BIT=4 (T=8, Tf=7) unless noted.
- Reset: hold `rst` for 3 cycles -> `txd`=1, `tx_busy`=0, `in_ready`=1, `fifo_count`=0, steady for 100 idle cycles.
- 8N1 with 0xA5 -> `txd` = 0,1,0,1,0,0,1,0,1 for 8 cycles each, then 1 for 7 cycles. `tx_busy` is high for exactly 79 cycles starting 2 edges after the push.
- Parity with 0x07, `parity_mode`=01 -> parity bit 1. With `parity_mode`=10 -> parity bit 0. Frame is 87 cycles. DATA_BITS=5 with `in_data`=0xFF -> only 5 ones are sent, then parity 1 (even).
- `two_stop`=1 with 0x00 -> after the last data bit, `txd` is high for 8+7=15 cycles before `tx_busy` falls.
- Burst with FIFO_DEPTH=4: hold `in_valid`=1 over data 1..8 -> 5 words accepted before `in_ready` falls (one is popped immediately). `in_ready` reasserts on each pop. All 8 frames appear in order with no idle cycle between the final stop bit and the next start bit.
- Reset mid-frame: assert `rst` during data bit 3 with 2 words queued -> `txd`=1 after that edge and `fifo_count`=0. Neither queued word is ever transmitted. A subsequent 0x3C is sent correctly.
